// File: rtl/fifo_sync_status_pkg.sv
// Shared definitions for the fifo_sync_status buffer.
// Holds the default geometry, the count-width helper, the threshold legality
// check used at elaboration, and the access-kind encoding used by the
// control logic.
package fifo_sync_status_pkg;

    localparam int DEF_DATA_SIZE    = 8;
    localparam int DEF_ADDRESS_BITS = 4;

    // Encoding of {write_accepted, read_accepted} for the pointer/count update.
    typedef enum logic [1:0] {
        ACC_IDLE  = 2'b00,
        ACC_READ  = 2'b01,
        ACC_WRITE = 2'b10,
        ACC_BOTH  = 2'b11
    } access_e;

    // Occupancy runs 0..DEPTH inclusive, so it needs one bit more than a pointer.
    function automatic int count_width(input int address_bits);
        return address_bits + 1;
    endfunction

    // Thresholds must satisfy 0 <= AE < AF <= DEPTH.
    function automatic bit thresholds_legal(input int ae, input int af, input int depth);
        return (ae >= 0) && (ae < af) && (af <= depth);
    endfunction

endpackage

// File: rtl/fifo_sync_status_mem.sv
// Storage array for fifo_sync_status: DEPTH x DATA_SIZE registers with one
// synchronous write port and one asynchronous (combinational) read port.
// The array is deliberately not reset.
// Ports:
//   clk    - write clock
//   we     - write enable
//   waddr  - write address
//   wdata  - write word
//   raddr  - read address
//   rdata  - word currently stored at raddr
module fifo_sync_status_mem #(
    parameter int DATA_SIZE    = 8,
    parameter int ADDRESS_BITS = 4
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [ADDRESS_BITS-1:0] waddr,
    input  logic [DATA_SIZE-1:0]    wdata,
    input  logic [ADDRESS_BITS-1:0] raddr,
    output logic [DATA_SIZE-1:0]    rdata
);

    localparam int DEPTH = 1 << ADDRESS_BITS;

    logic [DATA_SIZE-1:0] mem_r [DEPTH];

    // Synchronous write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/fifo_sync_status.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty flags,
// sticky overflow/underflow, synchronous flush and selectable read mode
// (registered read or first-word-fall-through).
// Ports:
//   clk, reset_n       - clock, asynchronous active-low reset
//   flush              - synchronous clear of pointers, count, flags, out_valid
//   clr_err            - synchronous clear of overflow/underflow
//   WEN, input_data    - write request and word
//   REN                - read (pop) request
//   output_data        - read word
//   out_valid          - output_data holds a popped (FWFT=0) or head (FWFT=1) word
//   empty, full        - count == 0 / count == DEPTH
//   almost_empty/full  - count <= AE_THRESH / count >= AF_THRESH
//   count              - occupancy 0..DEPTH
//   overflow/underflow - sticky error flags
module fifo_sync_status
    import fifo_sync_status_pkg::*;
#(
    parameter int DATA_SIZE    = DEF_DATA_SIZE,
    parameter int ADDRESS_BITS = DEF_ADDRESS_BITS,
    parameter int AF_THRESH    = (1 << ADDRESS_BITS) - 2,
    parameter int AE_THRESH    = 2,
    parameter int FWFT         = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  clr_err,
    input  logic                  WEN,
    input  logic                  REN,
    input  logic [DATA_SIZE-1:0]  input_data,
    output logic [DATA_SIZE-1:0]  output_data,
    output logic                  out_valid,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [ADDRESS_BITS:0] count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << ADDRESS_BITS;
    localparam int CW    = count_width(ADDRESS_BITS);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

    if (!thresholds_legal(AE_THRESH, AF_THRESH, DEPTH)) begin : g_bad_thresh
        $error("fifo_sync_status: thresholds must satisfy 0 <= AE_THRESH < AF_THRESH <= DEPTH");
    end

    logic [ADDRESS_BITS-1:0] wptr_r, rptr_r, wptr_s, rptr_s;
    logic [CW-1:0]           count_r, count_s;
    logic                    empty_r, full_r, ae_r, af_r;
    logic                    ovf_r, udf_r, ovf_s, udf_s;
    logic                    valid_r;
    logic [DATA_SIZE-1:0]    data_r;
    logic [DATA_SIZE-1:0]    rdata_s;
    logic                    wr_acc_s, rd_acc_s, mem_we_s;
    access_e                 acc_s;

    // Accept decisions, next pointers and next count; flush dominates traffic.
    always_comb begin
        wr_acc_s = WEN & ~full_r;
        rd_acc_s = REN & ~empty_r;
        acc_s    = access_e'({wr_acc_s, rd_acc_s});
        wptr_s   = wptr_r;
        rptr_s   = rptr_r;
        count_s  = count_r;
        if (flush) begin
            wptr_s  = {ADDRESS_BITS{1'b0}};
            rptr_s  = {ADDRESS_BITS{1'b0}};
            count_s = {CW{1'b0}};
        end else begin
            case (acc_s)
                ACC_WRITE: begin
                    wptr_s  = wptr_r + ADDRESS_BITS'(1);
                    count_s = count_r + CW'(1);
                end
                ACC_READ: begin
                    rptr_s  = rptr_r + ADDRESS_BITS'(1);
                    count_s = count_r - CW'(1);
                end
                ACC_BOTH: begin
                    wptr_s = wptr_r + ADDRESS_BITS'(1);
                    rptr_s = rptr_r + ADDRESS_BITS'(1);
                end
                default: begin
                    wptr_s = wptr_r;
                end
            endcase
        end
    end

    // Sticky errors: a fresh error in the clr_err cycle keeps the flag set.
    always_comb begin
        ovf_s = ovf_r;
        udf_s = udf_r;
        if (clr_err) begin
            ovf_s = 1'b0;
            udf_s = 1'b0;
        end else begin
            ovf_s = ovf_r;
            udf_s = udf_r;
        end
        ovf_s = ovf_s | (WEN & full_r);
        udf_s = udf_s | (REN & empty_r);
    end

    assign mem_we_s = wr_acc_s & ~flush;

    fifo_sync_status_mem #(
        .DATA_SIZE    (DATA_SIZE),
        .ADDRESS_BITS (ADDRESS_BITS)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we_s),
        .waddr (wptr_r),
        .wdata (input_data),
        .raddr (rptr_r),
        .rdata (rdata_s)
    );

    // Pointer, count, flag and error state; flags follow the next count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_r  <= {ADDRESS_BITS{1'b0}};
            rptr_r  <= {ADDRESS_BITS{1'b0}};
            count_r <= {CW{1'b0}};
            empty_r <= 1'b1;
            full_r  <= 1'b0;
            ae_r    <= 1'b1;
            af_r    <= 1'b0;
            ovf_r   <= 1'b0;
            udf_r   <= 1'b0;
        end else begin
            wptr_r  <= wptr_s;
            rptr_r  <= rptr_s;
            count_r <= count_s;
            empty_r <= (count_s == {CW{1'b0}});
            full_r  <= (count_s == DEPTH_C);
            ae_r    <= (count_s <= AE_C);
            af_r    <= (count_s >= AF_C);
            ovf_r   <= ovf_s;
            udf_r   <= udf_s;
        end
    end

    // Registered-read output stage: valid for exactly the cycle after a pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_r  <= {DATA_SIZE{1'b0}};
            valid_r <= 1'b0;
        end else if (flush) begin
            valid_r <= 1'b0;
        end else if (rd_acc_s) begin
            data_r  <= rdata_s;
            valid_r <= 1'b1;
        end else begin
            valid_r <= 1'b0;
        end
    end

    // In FWFT mode the head word is shown directly; it is forced to zero while
    // empty so the unreset array never leaks onto the output after reset.
    assign output_data  = (FWFT != 0) ? (empty_r ? {DATA_SIZE{1'b0}} : rdata_s) : data_r;
    assign out_valid    = (FWFT != 0) ? ~empty_r : valid_r;
    assign empty        = empty_r;
    assign full         = full_r;
    assign almost_empty = ae_r;
    assign almost_full  = af_r;
    assign count        = count_r;
    assign overflow     = ovf_r;
    assign underflow    = udf_r;

endmodule

// File: tb/tb_fifo_sync_status.sv
module tb_fifo_sync_status;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;

    // Instance 0: registered read (FWFT=0)
    logic       flush0 = 1'b0, clr0 = 1'b0, wen0 = 1'b0, ren0 = 1'b0;
    logic [7:0] din0 = 8'h00, dout0;
    logic       valid0, empty0, full0, ae0, af0, ovf0, udf0;
    logic [4:0] cnt0;

    // Instance 1: first-word-fall-through (FWFT=1)
    logic       flush1 = 1'b0, clr1 = 1'b0, wen1 = 1'b0, ren1 = 1'b0;
    logic [7:0] din1 = 8'h00, dout1;
    logic       valid1, empty1, full1, ae1, af1, ovf1, udf1;
    logic [4:0] cnt1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_sync_status #(.DATA_SIZE(8), .ADDRESS_BITS(4), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .flush(flush0), .clr_err(clr0),
        .WEN(wen0), .REN(ren0), .input_data(din0), .output_data(dout0),
        .out_valid(valid0), .empty(empty0), .full(full0),
        .almost_empty(ae0), .almost_full(af0), .count(cnt0),
        .overflow(ovf0), .underflow(udf0)
    );

    fifo_sync_status #(.DATA_SIZE(8), .ADDRESS_BITS(4), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .flush(flush1), .clr_err(clr1),
        .WEN(wen1), .REN(ren1), .input_data(din1), .output_data(dout1),
        .out_valid(valid1), .empty(empty1), .full(full1),
        .almost_empty(ae1), .almost_full(af1), .count(cnt1),
        .overflow(ovf1), .underflow(udf1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        reset_n = 1'b1;
        tick();

        // Reset state
        check("rst_count", 32'(cnt0), 32'd0);
        check("rst_empty", 32'(empty0), 32'd1);
        check("rst_ae", 32'(ae0), 32'd1);
        check("rst_full", 32'(full0), 32'd0);
        check("rst_af", 32'(af0), 32'd0);
        check("rst_ovf", 32'(ovf0), 32'd0);
        check("rst_udf", 32'(udf0), 32'd0);
        check("rst_valid", 32'(valid0), 32'd0);
        check("rst_dout", 32'(dout0), 32'd0);
        check("rst_valid_fwft", 32'(valid1), 32'd0);
        check("rst_dout_fwft", 32'(dout1), 32'd0);

        // FWFT: written word visible next cycle without REN
        wen1 = 1'b1; din1 = 8'hA5;
        tick();
        wen1 = 1'b0;
        check("fwft_dout", 32'(dout1), 32'hA5);
        check("fwft_valid", 32'(valid1), 32'd1);
        check("fwft_empty", 32'(empty1), 32'd0);
        tick();
        check("fwft_hold", 32'(dout1), 32'hA5);
        ren1 = 1'b1;
        tick();
        ren1 = 1'b0;
        check("fwft_pop_empty", 32'(empty1), 32'd1);
        check("fwft_pop_valid", 32'(valid1), 32'd0);
        check("fwft_pop_count", 32'(cnt1), 32'd0);

        // Fill 16 words
        for (int i = 1; i <= 16; i++) begin
            wen0 = 1'b1; din0 = 8'(i);
            tick();
            check("fill_count", 32'(cnt0), 32'(i));
            check("fill_full", 32'(full0), 32'(i == 16));
            check("fill_af", 32'(af0), 32'(i >= 14));
            check("fill_ae", 32'(ae0), 32'(i <= 2));
            check("fill_empty", 32'(empty0), 32'd0);
        end
        din0 = 8'h11;
        tick();
        wen0 = 1'b0;
        check("ovf_set", 32'(ovf0), 32'd1);
        check("ovf_count", 32'(cnt0), 32'd16);

        // Drain 16 words in registered-read mode
        for (int i = 1; i <= 16; i++) begin
            ren0 = 1'b1;
            tick();
            check("rd_valid", 32'(valid0), 32'd1);
            check("rd_data", 32'(dout0), 32'(i));
            check("rd_count", 32'(cnt0), 32'(16 - i));
        end
        ren0 = 1'b0;
        tick();
        check("rd_empty", 32'(empty0), 32'd1);
        check("rd_valid_drop", 32'(valid0), 32'd0);
        check("rd_data_hold", 32'(dout0), 32'h10);
        ren0 = 1'b1;
        tick();
        ren0 = 1'b0;
        check("udf_set", 32'(udf0), 32'd1);
        check("udf_valid", 32'(valid0), 32'd0);
        check("udf_count", 32'(cnt0), 32'd0);

        // Simultaneous traffic at count 5 across pointer wrap
        for (int i = 0; i < 5; i++) begin
            wen0 = 1'b1; din0 = 8'h20 + 8'(i);
            tick();
        end
        check("sim_pre_count", 32'(cnt0), 32'd5);
        for (int k = 0; k < 40; k++) begin
            wen0 = 1'b1; ren0 = 1'b1; din0 = 8'h25 + 8'(k);
            tick();
            check("sim_data", 32'(dout0), 32'h20 + 32'(k));
            check("sim_count", 32'(cnt0), 32'd5);
        end
        wen0 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            ren0 = 1'b1;
            tick();
            check("sim_drain", 32'(dout0), 32'h48 + 32'(k));
        end
        ren0 = 1'b0;
        check("sim_end_count", 32'(cnt0), 32'd0);

        // Flush at count 7 with WEN; errors untouched
        for (int i = 0; i < 7; i++) begin
            wen0 = 1'b1; din0 = 8'h60 + 8'(i);
            tick();
        end
        check("fl_pre_count", 32'(cnt0), 32'd7);
        flush0 = 1'b1; din0 = 8'h99;
        tick();
        flush0 = 1'b0; wen0 = 1'b0;
        check("fl_count", 32'(cnt0), 32'd0);
        check("fl_empty", 32'(empty0), 32'd1);
        check("fl_ae", 32'(ae0), 32'd1);
        check("fl_ovf_kept", 32'(ovf0), 32'd1);
        check("fl_udf_kept", 32'(udf0), 32'd1);
        wen0 = 1'b1; din0 = 8'h77;
        tick();
        wen0 = 1'b0; ren0 = 1'b1;
        tick();
        ren0 = 1'b0;
        check("fl_after_data", 32'(dout0), 32'h77);
        check("fl_after_count", 32'(cnt0), 32'd0);

        // Error clearing, and a new error beating clr_err
        clr0 = 1'b1;
        tick();
        clr0 = 1'b0;
        check("clr_ovf", 32'(ovf0), 32'd0);
        check("clr_udf", 32'(udf0), 32'd0);
        for (int i = 0; i < 16; i++) begin
            wen0 = 1'b1; din0 = 8'h80 + 8'(i);
            tick();
        end
        check("clr_full", 32'(full0), 32'd1);
        clr0 = 1'b1;
        tick();
        wen0 = 1'b0;
        check("clr_vs_ovf", 32'(ovf0), 32'd1);
        check("clr_vs_count", 32'(cnt0), 32'd16);
        tick();
        clr0 = 1'b0;
        check("clr_again", 32'(ovf0), 32'd0);
        flush0 = 1'b1;
        tick();
        flush0 = 1'b0;

        // Asynchronous reset mid-burst
        ren0 = 1'b1;
        tick();
        ren0 = 1'b0;
        check("pre_rst_udf", 32'(udf0), 32'd1);
        for (int i = 0; i < 3; i++) begin
            wen0 = 1'b1; din0 = 8'hC0 + 8'(i);
            tick();
        end
        ren0 = 1'b1;
        tick();
        check("pre_rst_valid", 32'(valid0), 32'd1);
        check("pre_rst_data", 32'(dout0), 32'hC0);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_count", 32'(cnt0), 32'd0);
        check("arst_empty", 32'(empty0), 32'd1);
        check("arst_ae", 32'(ae0), 32'd1);
        check("arst_af", 32'(af0), 32'd0);
        check("arst_valid", 32'(valid0), 32'd0);
        check("arst_dout", 32'(dout0), 32'd0);
        check("arst_udf", 32'(udf0), 32'd0);
        wen0 = 1'b0; ren0 = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        check("post_rst_count", 32'(cnt0), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_sync_status.md
Name: fifo_sync_status

Overview:
- Parametrised single-clock FIFO that succeeds the team's basic 8x8 FIFO.
- Adds arbitrary power-of-two depth, an occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, synchronous flush and a selectable first-word-fall-through (FWFT) read mode.
- Sits between a producer and a consumer in the same clock domain as the standard buffering element.

Parameters:
- DATA_SIZE, 8, word width in bits.
- ADDRESS_BITS, 4, pointer width; DEPTH = 2**ADDRESS_BITS words.
- AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH.
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH.
- FWFT, 0, read mode: 0 = registered read, 1 = first-word-fall-through.
- Legal range: 0 <= AE_THRESH < AF_THRESH <= DEPTH.

Ports:
- clk  in  1  single clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of pointers, count and valid state.
- clr_err  in  1  synchronous clear of overflow/underflow.
- WEN  in  1  write request.
- REN  in  1  read request (pop).
- input_data  in  DATA_SIZE  write word.
- output_data  out  DATA_SIZE  read word.
- out_valid  out  1  output_data carries a valid popped or head word.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- almost_empty  out  1  count <= AE_THRESH.
- almost_full  out  1  count >= AF_THRESH.
- count  out  ADDRESS_BITS+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.

Behaviour:
- Reset (reset_n low, asynchronous):
  - wptr = rptr = 0, count = 0.
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0.
  - overflow = underflow = 0, out_valid = 0, output_data = 0.
  - Memory is not reset.
- Reset mid-operation discards all contents immediately.
- Accept rules:
  - Write accepted iff WEN && !full.
  - Read accepted iff REN && !empty.
  - Both use the registered flags of the current cycle.
- Accepted write: mem[wptr] <= input_data; wptr increments modulo DEPTH (natural wrap).
- Accepted read: rptr increments modulo DEPTH.
- Count update:
  - +1 on write only, -1 on read only.
  - Unchanged when both are accepted in the same cycle, including at count == 1 and count == DEPTH-1.
  - Read and write both accepted at full is impossible (write is rejected).
- Flags are registered and computed from next-count, so they are valid the same cycle count is.
  - First write into an empty FIFO deasserts empty one clock after the accepting edge.
- Read mode FWFT = 0:
  - output_data <= mem[rptr] on an accepted read; out_valid = 1 for exactly that next cycle.
  - Otherwise out_valid = 0 and output_data holds its last value (never driven Z).
- Read mode FWFT = 1:
  - output_data = mem[rptr] combinationally; out_valid = !empty.
  - REN pops the displayed word; the next word appears after that edge.
  - A written word is visible on output_data the cycle after its write edge.
- Errors:
  - overflow sets on WEN && full; underflow sets on REN && empty.
  - Rejected accesses change no pointer or count.
  - clr_err clears both flags; a new error in the same cycle as clr_err wins (flag stays 1).
- flush:
  - Forces pointers/count/flags to reset values and out_valid to 0 on the next edge.
  - Dominates WEN/REN in the same cycle (no write stored, no pop).
  - Does not clear overflow/underflow.

Decomposition:
- Shared header/package fifo_defs holds:
  - default DATA_SIZE/ADDRESS_BITS;
  - the function computing count width (ADDRESS_BITS+1);
  - the threshold-legality check macro, used by elaboration-time assertions.
- One sub-module, fifo_mem: DEPTH x DATA_SIZE register array with synchronous write port and asynchronous read port.
- Control, count, flags and read-mode logic stay in fifo_sync_status.

Test Plan (DATA_SIZE 8, ADDRESS_BITS 4, AF 14, AE 2):
- Reset then write 0x01..0x10 (16 words) with REN=0 -> count 16, full=1, almost_full from count 14, almost_empty drops at count 3; a 17th WEN sets overflow=1, count stays 16.
- From full, read 16 times in FWFT=0 -> output_data 0x01..0x10, each one cycle after its read with out_valid=1; empty=1 after last; extra REN sets underflow=1.
- Simultaneous WEN/REN for 40 cycles at count 5 (pointers wrap twice) -> count stays 5, data order preserved across wrap.
- FWFT=1: write 0xA5 into empty FIFO -> output_data=0xA5, out_valid=1 on the next cycle without REN; REN pops, empty=1 after the edge.
- At count 7, assert flush with WEN=1 -> count 0, empty=1, written word discarded; overflow state unchanged; clr_err together with WEN&&full keeps overflow=1.
- Assert reset_n low mid-burst between edges -> all outputs reach reset values immediately, before the next clock edge.
